// File: rtl/fpu_defs_div_sqrt_tp.sv
// Shared constants and types for the divide/sqrt result post-processing path.
package fpu_defs_div_sqrt_tp;

  localparam int C_DIV_OP     = 32;
  localparam int C_DIV_EXP    = 8;
  localparam int C_DIV_MANT   = 23;
  localparam int C_DIV_RM     = 2;
  localparam int C_DIV_FFLAGS = 5;

  localparam logic [C_DIV_EXP-1:0]  C_DIV_EXP_INF   = 8'hFF;
  localparam logic [C_DIV_OP-1:0]   C_DIV_QNAN      = 32'h7FC00000;
  localparam logic [C_DIV_OP-2:0]   C_DIV_MAXFINITE = 31'h7F7FFFFF;

  localparam logic [C_DIV_RM-1:0] C_RM_NEAREST = 2'b00;
  localparam logic [C_DIV_RM-1:0] C_RM_TRUNC   = 2'b01;
  localparam logic [C_DIV_RM-1:0] C_RM_MINUS   = 2'b10;
  localparam logic [C_DIV_RM-1:0] C_RM_PLUS    = 2'b11;

  localparam logic [C_DIV_FFLAGS-1:0] C_FLAG_NV = 5'b10000;
  localparam logic [C_DIV_FFLAGS-1:0] C_FLAG_DZ = 5'b01000;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_NORM  = 2'd1,
    S_ROUND = 2'd2,
    S_DONE  = 2'd3
  } pp_state_e;

endpackage

// File: rtl/postprocess_round.sv
// Rounding decision and increment on the packed {exponent, fraction} magnitude;
// a fraction carry-out naturally bumps the exponent field.
module postprocess_round
  import fpu_defs_div_sqrt_tp::*;
(
  input  logic [C_DIV_RM-1:0] rm_i,
  input  logic                sign_i,
  input  logic [C_DIV_OP-2:0] mag_i,
  input  logic                guard_i,
  input  logic                sticky_i,
  output logic [C_DIV_OP-2:0] mag_o
);

  logic inc;

  always_comb begin
    inc = 1'b0;
    unique case (rm_i)
      C_RM_NEAREST: inc = guard_i && (sticky_i || mag_i[0]);
      C_RM_TRUNC:   inc = 1'b0;
      C_RM_MINUS:   inc = sign_i && (guard_i || sticky_i);
      C_RM_PLUS:    inc = !sign_i && (guard_i || sticky_i);
      default:      inc = 1'b0;
    endcase
    mag_o = mag_i + {{(C_DIV_OP-2){1'b0}}, inc};
  end

endmodule

// File: rtl/postprocess_pack.sv
// Normalise, round and pack a div/sqrt core result into IEEE-754 single precision,
// with special-operand handling and a valid/ready output handshake.
module postprocess_pack
  import fpu_defs_div_sqrt_tp::*;
(
  input  logic                    Clk_CI,
  input  logic                    Rst_RBI,
  input  logic                    Start_SI,
  input  logic                    Div_enable_SI,
  input  logic                    Sqrt_enable_SI,
  input  logic                    Sign_z_DI,
  input  logic [C_DIV_EXP+1:0]    Exp_z_DI,
  input  logic [C_DIV_MANT+1:0]   Mant_z_DI,
  input  logic                    Sticky_SI,
  input  logic [C_DIV_RM-1:0]     RM_SI,
  input  logic                    Inf_a_SI,
  input  logic                    Inf_b_SI,
  input  logic                    Zero_a_SI,
  input  logic                    Zero_b_SI,
  input  logic                    NaN_a_SI,
  input  logic                    NaN_b_SI,
  input  logic                    Ready_SI,
  output logic                    Busy_SO,
  output logic                    Valid_SO,
  output logic [C_DIV_OP-1:0]     Result_DO,
  output logic [C_DIV_FFLAGS-1:0] Fflags_SO
);

  localparam int MANT_W = C_DIV_MANT + 2;

  pp_state_e state_q, state_d;
  logic div_q, div_d, sign_q, sign_d, sticky_q, sticky_d;
  logic [C_DIV_EXP+1:0] exp_q, exp_d;
  logic [MANT_W-1:0] mant_q, mant_d;
  logic [C_DIV_RM-1:0] rm_q, rm_d;
  logic inf_a_q, inf_a_d, inf_b_q, inf_b_d, zero_a_q, zero_a_d;
  logic zero_b_q, zero_b_d, nan_a_q, nan_a_d, nan_b_q, nan_b_d;
  logic [C_DIV_OP-2:0] mag_q, mag_d;
  logic guard_q, guard_d, rsticky_q, rsticky_d, tiny_q, tiny_d, ovf_q, ovf_d;
  logic special_q, special_d;
  logic [C_DIV_OP-1:0] spec_res_q, spec_res_d;
  logic [C_DIV_FFLAGS-1:0] spec_flags_q, spec_flags_d;
  logic [C_DIV_OP-1:0] result_q, result_d;
  logic [C_DIV_FFLAGS-1:0] fflags_q, fflags_d;
  logic valid_q, valid_d;

  logic handoff, capture, exp_ovf, exp_le_zero;
  logic signed [C_DIV_EXP+2:0] shift_amt;
  logic [4:0] shift_sat;
  logic [2*MANT_W-1:0] shifted;
  logic [C_DIV_OP-2:0] rounded_mag;
  logic spec_hit, final_ovf, final_nx, inf_sel;
  logic [C_DIV_OP-1:0] spec_res;
  logic [C_DIV_FFLAGS-1:0] spec_flags;

  postprocess_round u_round (
    .rm_i     (rm_q),
    .sign_i   (sign_q),
    .mag_i    (mag_q),
    .guard_i  (guard_q),
    .sticky_i (rsticky_q),
    .mag_o    (rounded_mag)
  );

  assign handoff  = (state_q == S_DONE) && valid_q && Ready_SI;
  assign capture  = Start_SI && ((state_q == S_IDLE) || handoff);
  assign Busy_SO  = (state_q != S_IDLE) && !handoff;
  assign Valid_SO = valid_q;
  assign Result_DO = result_q;
  assign Fflags_SO = fflags_q;

  // Denormalising shift: the amount saturates once every mantissa bit has left.
  always_comb begin
    exp_ovf     = $signed(exp_q) >= 10'sd255;
    exp_le_zero = $signed(exp_q) <= 10'sd0;
    shift_amt   = 11'sd1 - $signed({exp_q[C_DIV_EXP+1], exp_q});
    shift_sat   = (shift_amt > 11'sd25) ? 5'd25 : shift_amt[4:0];
    shifted     = {mant_q, {MANT_W{1'b0}}} >> shift_sat;
  end

  always_comb begin
    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (nan_a_q || nan_b_q) begin
      spec_hit = 1'b1;
      spec_res = C_DIV_QNAN;
    end else if (div_q) begin
      if ((zero_a_q && zero_b_q) || (inf_a_q && inf_b_q)) begin
        spec_hit   = 1'b1;
        spec_res   = C_DIV_QNAN;
        spec_flags = C_FLAG_NV;
      end else if (inf_a_q) begin
        spec_hit = 1'b1;
        spec_res = {sign_q, C_DIV_EXP_INF, {C_DIV_MANT{1'b0}}};
      end else if (zero_b_q) begin
        spec_hit   = 1'b1;
        spec_res   = {sign_q, C_DIV_EXP_INF, {C_DIV_MANT{1'b0}}};
        spec_flags = C_FLAG_DZ;
      end else if (zero_a_q || inf_b_q) begin
        spec_hit = 1'b1;
        spec_res = {sign_q, {(C_DIV_OP-1){1'b0}}};
      end
    end else begin
      if (zero_a_q) begin
        spec_hit = 1'b1;
        spec_res = {sign_q, {(C_DIV_OP-1){1'b0}}};
      end else if (sign_q) begin
        spec_hit   = 1'b1;
        spec_res   = C_DIV_QNAN;
        spec_flags = C_FLAG_NV;
      end else if (inf_a_q) begin
        spec_hit = 1'b1;
        spec_res = {1'b0, C_DIV_EXP_INF, {C_DIV_MANT{1'b0}}};
      end
    end
  end

  always_comb begin
    final_ovf = ovf_q || (rounded_mag[C_DIV_OP-2 -: C_DIV_EXP] == C_DIV_EXP_INF);
    final_nx  = guard_q || rsticky_q || final_ovf;
    inf_sel   = (rm_q == C_RM_NEAREST) || ((rm_q == C_RM_PLUS) && !sign_q) ||
                ((rm_q == C_RM_MINUS) && sign_q);
  end

  always_comb begin
    state_d = state_q;
    div_d = div_q; sign_d = sign_q; exp_d = exp_q; mant_d = mant_q;
    sticky_d = sticky_q; rm_d = rm_q;
    inf_a_d = inf_a_q; inf_b_d = inf_b_q; zero_a_d = zero_a_q;
    zero_b_d = zero_b_q; nan_a_d = nan_a_q; nan_b_d = nan_b_q;
    mag_d = mag_q; guard_d = guard_q; rsticky_d = rsticky_q;
    tiny_d = tiny_q; ovf_d = ovf_q;
    special_d = special_q; spec_res_d = spec_res_q; spec_flags_d = spec_flags_q;
    result_d = result_q; fflags_d = fflags_q; valid_d = valid_q;

    unique case (state_q)
      S_IDLE: if (capture) state_d = S_NORM;
      S_NORM: begin
        state_d      = S_ROUND;
        special_d    = spec_hit;
        spec_res_d   = spec_res;
        spec_flags_d = spec_flags;
        ovf_d        = exp_ovf;
        tiny_d       = exp_le_zero;
        if (exp_ovf) begin
          mag_d     = '0;
          guard_d   = 1'b0;
          rsticky_d = sticky_q;
        end else if (exp_le_zero) begin
          mag_d     = {{(C_DIV_EXP-1){1'b0}}, shifted[2*MANT_W-1:MANT_W+1]};
          guard_d   = shifted[MANT_W];
          rsticky_d = sticky_q || (|shifted[MANT_W-1:0]);
        end else begin
          mag_d     = {exp_q[C_DIV_EXP-1:0], mant_q[MANT_W-2:1]};
          guard_d   = mant_q[0];
          rsticky_d = sticky_q;
        end
      end
      S_ROUND: begin
        state_d = S_DONE;
        valid_d = 1'b1;
        if (special_q) begin
          result_d = spec_res_q;
          fflags_d = spec_flags_q;
        end else begin
          if (final_ovf)
            result_d = inf_sel ? {sign_q, C_DIV_EXP_INF, {C_DIV_MANT{1'b0}}}
                               : {sign_q, C_DIV_MAXFINITE};
          else
            result_d = {sign_q, rounded_mag};
          fflags_d = {2'b00, final_ovf, tiny_q && final_nx && !final_ovf, final_nx};
        end
      end
      S_DONE: if (handoff) begin
        valid_d = 1'b0;
        state_d = capture ? S_NORM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (capture) begin
      div_d    = Div_enable_SI && !Sqrt_enable_SI;
      sign_d   = Sign_z_DI;
      exp_d    = Exp_z_DI;
      mant_d   = Mant_z_DI;
      sticky_d = Sticky_SI;
      rm_d     = RM_SI;
      inf_a_d  = Inf_a_SI;  inf_b_d  = Inf_b_SI;
      zero_a_d = Zero_a_SI; zero_b_d = Zero_b_SI;
      nan_a_d  = NaN_a_SI;  nan_b_d  = NaN_b_SI;
    end
  end

  always_ff @(posedge Clk_CI) begin
    if (!Rst_RBI) begin
      state_q <= S_IDLE;
      div_q <= 1'b0; sign_q <= 1'b0; exp_q <= '0; mant_q <= '0;
      sticky_q <= 1'b0; rm_q <= '0;
      inf_a_q <= 1'b0; inf_b_q <= 1'b0; zero_a_q <= 1'b0;
      zero_b_q <= 1'b0; nan_a_q <= 1'b0; nan_b_q <= 1'b0;
      mag_q <= '0; guard_q <= 1'b0; rsticky_q <= 1'b0;
      tiny_q <= 1'b0; ovf_q <= 1'b0;
      special_q <= 1'b0; spec_res_q <= '0; spec_flags_q <= '0;
      result_q <= '0; fflags_q <= '0; valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q <= div_d; sign_q <= sign_d; exp_q <= exp_d; mant_q <= mant_d;
      sticky_q <= sticky_d; rm_q <= rm_d;
      inf_a_q <= inf_a_d; inf_b_q <= inf_b_d; zero_a_q <= zero_a_d;
      zero_b_q <= zero_b_d; nan_a_q <= nan_a_d; nan_b_q <= nan_b_d;
      mag_q <= mag_d; guard_q <= guard_d; rsticky_q <= rsticky_d;
      tiny_q <= tiny_d; ovf_q <= ovf_d;
      special_q <= special_d; spec_res_q <= spec_res_d; spec_flags_q <= spec_flags_d;
      result_q <= result_d; fflags_q <= fflags_d; valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_postprocess_pack.sv
// Directed scoreboard bench for postprocess_pack: expected results are queued at
// issue time and popped when the DUT raises Valid_SO.
module tb_postprocess_pack;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, div_en = 1'b0, sqrt_en = 1'b0, sign = 1'b0;
  logic [9:0]  exp_z = '0;
  logic [24:0] mant_z = '0;
  logic        sticky = 1'b0;
  logic [1:0]  rm = '0;
  logic        inf_a = 1'b0, inf_b = 1'b0, zero_a = 1'b0, zero_b = 1'b0;
  logic        nan_a = 1'b0, nan_b = 1'b0;
  logic        ready = 1'b0;
  logic        busy, valid;
  logic [31:0] result;
  logic [4:0]  fflags;

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  flags;
  } exp_t;

  exp_t sb_q[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  localparam logic [1:0] RNE = 2'b00, RTZ = 2'b01, RDN = 2'b10, RUP = 2'b11;
  localparam logic [5:0] C_NONE = 6'b000000, C_INF_A = 6'b100000, C_INF_B = 6'b010000;
  localparam logic [5:0] C_ZERO_A = 6'b001000, C_ZERO_B = 6'b000100, C_NAN_A = 6'b000010;
  localparam logic [4:0] F_NV = 5'b10000, F_DZ = 5'b01000, F_OF = 5'b00100;
  localparam logic [4:0] F_UF = 5'b00010, F_NX = 5'b00001;

  postprocess_pack dut (
    .Clk_CI         (clk),
    .Rst_RBI        (rst_n),
    .Start_SI       (start),
    .Div_enable_SI  (div_en),
    .Sqrt_enable_SI (sqrt_en),
    .Sign_z_DI      (sign),
    .Exp_z_DI       (exp_z),
    .Mant_z_DI      (mant_z),
    .Sticky_SI      (sticky),
    .RM_SI          (rm),
    .Inf_a_SI       (inf_a),
    .Inf_b_SI       (inf_b),
    .Zero_a_SI      (zero_a),
    .Zero_b_SI      (zero_b),
    .NaN_a_SI       (nan_a),
    .NaN_b_SI       (nan_b),
    .Ready_SI       (ready),
    .Busy_SO        (busy),
    .Valid_SO       (valid),
    .Result_DO      (result),
    .Fflags_SO      (fflags)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vectors++;
    assert (obs === expv) else begin
      n_miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic d, input logic s, input logic [9:0] e,
                               input logic [24:0] m, input logic st, input logic [1:0] r,
                               input logic [5:0] cls, input logic [31:0] eres,
                               input logic [4:0] eflg, input bit push);
    div_en  = d;
    sqrt_en = !d;
    sign    = s;
    exp_z   = e;
    mant_z  = m;
    sticky  = st;
    rm      = r;
    {inf_a, inf_b, zero_a, zero_b, nan_a, nan_b} = cls;
    start   = 1'b1;
    if (push) sb_q.push_back('{res: eres, flags: eflg});
  endtask

  task automatic checkOutput(input string tag);
    int   edges;
    exp_t e;
    edges = 1;
    while (valid !== 1'b1 && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, "_latency"}, edges, 3);
    check({tag, "_valid"}, {31'b0, valid}, 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_result"}, result, e.res);
      check({tag, "_flags"}, {27'b0, fflags}, {27'b0, e.flags});
    end
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    ready = 1'b1;
    #1 check({tag, "_busy_handoff"}, {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, {31'b0, valid}, 32'd0);
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic run_vector(input string tag, input logic d, input logic s,
                            input logic [9:0] e, input logic [24:0] m, input logic st,
                            input logic [1:0] r, input logic [5:0] cls,
                            input logic [31:0] eres, input logic [4:0] eflg);
    @(negedge clk);
    applyStimulus(d, s, e, m, st, r, cls, eres, eflg, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput(tag);
    handshake(tag);
  endtask

  initial begin
    $display("[TB] postprocess_pack bench starting");
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", {31'b0, valid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", {27'b0, fflags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_vector("div_basic", 1, 0, 10'd128, 25'h1800000, 0, RNE, C_NONE, 32'h40400000, 5'd0);
    run_vector("div_by_zero", 1, 0, 10'd128, 25'h1800000, 0, RNE, C_ZERO_B, 32'h7F800000, F_DZ);
    run_vector("div_zero_zero", 1, 0, 10'd0, 25'h0, 0, RNE, C_ZERO_A | C_ZERO_B, 32'h7FC00000, F_NV);
    run_vector("div_inf_inf", 1, 1, 10'd0, 25'h0, 0, RNE, C_INF_A | C_INF_B, 32'h7FC00000, F_NV);
    run_vector("div_inf_x", 1, 1, 10'd0, 25'h0, 0, RNE, C_INF_A, 32'hFF800000, 5'd0);
    run_vector("div_x_inf", 1, 1, 10'd0, 25'h0, 0, RNE, C_INF_B, 32'h80000000, 5'd0);
    run_vector("nan_in", 1, 1, 10'd128, 25'h1800000, 1, RNE, C_NAN_A, 32'h7FC00000, 5'd0);
    run_vector("sqrt_neg", 0, 1, 10'd127, 25'h1000000, 0, RNE, C_NONE, 32'h7FC00000, F_NV);
    run_vector("sqrt_negzero", 0, 1, 10'd0, 25'h0, 0, RNE, C_ZERO_A, 32'h80000000, 5'd0);
    run_vector("sqrt_posinf", 0, 0, 10'd0, 25'h0, 0, RNE, C_INF_A, 32'h7F800000, 5'd0);
    run_vector("ovf_rtz", 1, 0, 10'd300, 25'h1000000, 0, RTZ, C_NONE, 32'h7F7FFFFF, F_OF | F_NX);
    run_vector("ovf_rne", 1, 0, 10'd300, 25'h1000000, 0, RNE, C_NONE, 32'h7F800000, F_OF | F_NX);
    run_vector("ovf_rdn_pos", 1, 0, 10'd300, 25'h1000000, 0, RDN, C_NONE, 32'h7F7FFFFF, F_OF | F_NX);
    run_vector("carry_exp", 1, 0, 10'd127, 25'h1FFFFFF, 0, RNE, C_NONE, 32'h40000000, F_NX);
    run_vector("carry_ovf", 1, 0, 10'd254, 25'h1FFFFFF, 0, RNE, C_NONE, 32'h7F800000, F_OF | F_NX);
    run_vector("rne_tie_even", 1, 0, 10'd127, 25'h1000001, 0, RNE, C_NONE, 32'h3F800000, F_NX);
    run_vector("rup_pos", 1, 0, 10'd127, 25'h1000000, 1, RUP, C_NONE, 32'h3F800001, F_NX);
    run_vector("rdn_neg", 1, 1, 10'd127, 25'h1000000, 1, RDN, C_NONE, 32'hBF800001, F_NX);
    run_vector("denorm", 1, 0, 10'h3FB, 25'h1000000, 1, RNE, C_NONE, 32'h00020000, F_UF | F_NX);
    run_vector("denorm_carry", 1, 0, 10'd0, 25'h1FFFFFF, 0, RNE, C_NONE, 32'h00800000, F_UF | F_NX);

    // Hold in DONE with Ready low while Start is pulsed; then a same-cycle hand-off.
    @(negedge clk);
    applyStimulus(1, 0, 10'd128, 25'h1800000, 0, RNE, C_NONE, 32'h40400000, 5'd0, 1'b1);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checkOutput("hold_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(1, 0, 10'd300, 25'h1000000, 0, RTZ, C_NONE, 32'h0, 5'd0, 1'b0);
      @(posedge clk); #1;
      check("hold_result", result, 32'h40400000);
      check("hold_valid", {31'b0, valid}, 32'd1);
      check("hold_busy", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    applyStimulus(1, 0, 10'd127, 25'h1FFFFFF, 0, RNE, C_NONE, 32'h40000000, F_NX, 1'b1);
    ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    ready = 1'b0;
    checkOutput("handoff");
    handshake("handoff");

    // Reset while an operation is in flight must discard it.
    @(negedge clk);
    applyStimulus(1, 0, 10'd128, 25'h1800000, 0, RNE, C_NONE, 32'h0, 5'd0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", {31'b0, valid}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_flags", {27'b0, fflags}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("midrst_no_result", {31'b0, valid}, 32'd0);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/postprocess_pack.md
POSTPROCESS_PACK -- requirements
Module: postprocess_pack

Interface
REQ-001 SHALL expose Clk_CI  in  1  rising-edge clock.
REQ-002 SHALL expose Rst_RBI  in  1  reset; synchronous, active-low.
REQ-003 SHALL expose Start_SI  in  1  result-core handshake; sampled only in IDLE or on DONE hand-off.
REQ-004 SHALL expose Div_enable_SI / Sqrt_enable_SI  in  1 each  operation select; exactly one high with Start_SI.
REQ-005 SHALL expose Sign_z_DI  in  1  result sign; for sqrt, the sign of operand a.
REQ-006 SHALL expose Exp_z_DI  in  C_DIV_EXP+2  two's-complement biased exponent.
REQ-007 SHALL expose Mant_z_DI  in  C_DIV_MANT+2  {integer bit, fraction, guard}; integer bit 1 for finite non-zero.
REQ-008 SHALL expose Sticky_SI  in  1  OR of remainder bits.
REQ-009 SHALL expose RM_SI  in  C_DIV_RM  rounding mode: 00 RNE, 01 RTZ, 10 RDN, 11 RUP.
REQ-010 SHALL expose Inf_a_SI, Inf_b_SI, Zero_a_SI, Zero_b_SI, NaN_a_SI, NaN_b_SI  in  1 each  operand class flags.
REQ-011 SHALL expose Busy_SO  out  1  high whenever a new Start_SI would be ignored.
REQ-012 SHALL expose Valid_SO  out  1  result valid; Ready_SI  in  1  downstream accept.
REQ-013 SHALL expose Result_DO  out  C_DIV_OP  packed IEEE-754 result; Fflags_SO  out  5  {NV,DZ,OF,UF,NX}.

Function
REQ-014 SHALL implement FSM IDLE -> NORM -> ROUND -> DONE; Start_SI in IDLE captures all inputs and moves to NORM.
REQ-015 SHALL advance NORM->ROUND and ROUND->DONE unconditionally; Valid_SO high exactly 3 edges after the capturing edge.
REQ-016 SHALL hold Result_DO, Fflags_SO, Valid_SO stable in DONE until Valid_SO && Ready_SI, then go to IDLE.
REQ-017 SHALL, when Valid_SO && Ready_SI && Start_SI coincide, capture the new operation and go directly to NORM (no bubble).
REQ-018 SHALL ignore Start_SI in NORM, ROUND, and DONE without Ready_SI; Busy_SO = (state != IDLE) && !(DONE && Ready_SI).
REQ-019 SHALL, in NORM, for Exp_z_DI <= 0 right-shift the mantissa by 1-Exp_z_DI (saturating at C_DIV_MANT+2), OR shifted-out bits into sticky, and set the exponent field to 0; tiny = (Exp_z_DI <= 0) before rounding.
REQ-020 SHALL, in ROUND, increment on: RNE guard&&(sticky||lsb); RTZ never; RDN sign&&(guard||sticky); RUP !sign&&(guard||sticky).
REQ-021 SHALL propagate rounding carry-out into the exponent (denormal -> 0x01 normal; 0xFE -> overflow).
REQ-022 SHALL, on overflow (Exp_z_DI >= 255 or carry to 255), set OF|NX; result Inf for RNE, RUP(+), RDN(-); else max finite 0x7F7FFFFF with sign.
REQ-023 SHALL set NX = guard||sticky after the shift, or overflow; UF = tiny && NX.
REQ-024 SHALL apply specials with priority over arithmetic: any NaN -> 0x7FC00000, no flags; div 0/0 or Inf/Inf -> 0x7FC00000, NV; div finite/0 -> signed Inf, DZ; div Inf/x -> signed Inf; div 0/x or x/Inf -> signed zero.
REQ-025 SHALL produce sqrt(-0)=-0, sqrt(+Inf)=+Inf, sqrt(+0)=+0, and sqrt(negative non-zero or -Inf) -> 0x7FC00000, NV.
REQ-026 SHALL clear Fflags_SO except flags of the current result; special-case results carry no OF/UF/NX.

Reset
REQ-027 SHALL, while Rst_RBI low at a rising edge, force state IDLE, Valid_SO 0, Busy_SO 0, Result_DO 0, Fflags_SO 0, all capture registers 0.
REQ-028 SHALL abort an in-flight operation on mid-operation reset; no result is presented afterwards.

Structure
REQ-029 SHALL take C_DIV_OP(32), C_DIV_EXP(8), C_DIV_MANT(23), C_DIV_RM(2), C_DIV_EXP_INF from fpu_defs_div_sqrt_tp; SHALL add C_DIV_QNAN, C_DIV_MAXFINITE, C_DIV_FFLAGS(5), rounding-mode constants, and the FSM state enum there.
REQ-030 SHALL place the rounding decision and increment in one combinational sub-module, postprocess_round.

Verification
REQ-031 Div, Sign 0, Exp 128, Mant {1,0x400000,0}, sticky 0, RNE -> 0x40400000, flags 0, Valid_SO on 3rd edge.
REQ-032 Div, Zero_b_SI=1, a finite, sign 0 -> 0x7F800000, DZ; Zero_a=Zero_b=1 -> 0x7FC00000, NV.
REQ-033 Sqrt, Sign 1, finite non-zero -> 0x7FC00000, NV; Sqrt, Zero_a, Sign 1 -> 0x80000000.
REQ-034 Exp 300, sign 0, RTZ -> 0x7F7FFFFF, OF|NX; same with RNE -> 0x7F800000, OF|NX.
REQ-035 Exp 127, fraction all ones, guard 1, sticky 0, RNE -> 0x40000000, NX; Exp -5, sticky 1 -> denormal, UF|NX.
REQ-036 Ready_SI low 5 cycles in DONE with Start_SI pulsed -> Result_DO stable, Start ignored; Ready_SI+Start_SI same cycle -> next result 3 edges later.
